// File: rtl/multi_sum_serializer_pkg.sv
// Shared definitions for the multi-operand sum serializer.
//   state_t      : frame sequencer states
//   sum_w()      : result width that cannot overflow for n_ops operands of op_w bits
//   DEF_*        : default parameter values
package multi_sum_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int DEF_N_OPS     = 3;
    localparam int DEF_OP_W      = 9;
    localparam int DEF_MSB_FIRST = 0;
    localparam int DEF_BIT_DIV   = 1;
    localparam int DEF_GAP_CYC   = 2;

    // Each doubling of the operand count needs one more carry bit.
    function automatic int sum_w(input int n_ops, input int op_w);
        return op_w + $clog2(n_ops);
    endfunction

endpackage

// File: rtl/multi_sum_serializer_bit_tick_gen.sv
// Bit-period strobe generator.
//   clk  : clock
//   rst  : synchronous reset, active-high
//   clr  : restart the period so the next tick lands BIT_DIV cycles later
//   tick : high in the last cycle of every BIT_DIV-cycle period
module bit_tick_gen
    import multi_sum_ser_pkg::*;
#(
    parameter int BIT_DIV = DEF_BIT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    if (BIT_DIV == 1) begin : g_div1
        // Every cycle is a full bit period; no counter needed.
        logic unused_in;
        assign unused_in = &{1'b0, clk, rst, clr};
        assign tick      = 1'b1;
    end else begin : g_divn
        localparam int CW = $clog2(BIT_DIV);
        localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);

        logic [CW-1:0] cnt;

        always_ff @(posedge clk) begin
            if (rst || clr) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign tick = (cnt == LAST);
    end

endmodule

// File: rtl/multi_sum_serializer.sv
// Adds N_OPS packed unsigned operands without truncation and shifts the
// SUM_W-bit result out serially, framed by an active-low enable.
// A one-entry pending buffer accepts a request while a frame is in flight.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous reset, active-high
//   start_i : request pulse, data_i sampled in the same cycle
//   data_i  : operands, op k = data_i[k*OP_W +: OP_W]
//   busy_o  : frame in flight or pending
//   full_o  : pending buffer occupied
//   drop_o  : one-cycle pulse after a request was discarded (buffer full)
//   ena_o   : frame enable, active-low, low for SUM_W*BIT_DIV cycles
//   data_o  : serial data, valid while ena_o=0, else 0
//   done_o  : one-cycle pulse in the cycle after the last bit period
module multi_sum_serializer
    import multi_sum_ser_pkg::*;
#(
    parameter int N_OPS     = DEF_N_OPS,
    parameter int OP_W      = DEF_OP_W,
    parameter int SUM_W     = sum_w(N_OPS, OP_W),
    parameter int MSB_FIRST = DEF_MSB_FIRST,
    parameter int BIT_DIV   = DEF_BIT_DIV,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [N_OPS*OP_W-1:0] data_i,
    output logic                  busy_o,
    output logic                  full_o,
    output logic                  drop_o,
    output logic                  ena_o,
    output logic                  data_o,
    output logic                  done_o
);

    localparam int BCW = $clog2(SUM_W + 1);
    localparam int GCW = $clog2(GAP_CYC + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(SUM_W - 1);
    // Without a pending frame the GAP state lasts GAP_CYC cycles. With one,
    // GAP is left a cycle early so that the LOAD cycle completes the
    // GAP_CYC-cycle high interval between back-to-back frames (GAP always
    // lasts at least one cycle, which carries done_o).
    localparam logic [GCW-1:0] GAP_END = GCW'(GAP_CYC - 1);
    localparam logic [GCW-1:0] GAP_REL = (GAP_CYC >= 2) ? GCW'(GAP_CYC - 2) : '0;

    // Zero-extend every operand to SUM_W and accumulate; no bits lost.
    function automatic logic [SUM_W-1:0] sum_ops(input logic [N_OPS*OP_W-1:0] ops);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < N_OPS; k++) begin
            acc = acc + SUM_W'(ops[k*OP_W +: OP_W]);
        end
        return acc;
    endfunction

    state_t           state, state_nxt;
    logic [SUM_W-1:0] sum_p0;
    logic [SUM_W-1:0] shreg;
    logic [SUM_W-1:0] pend;
    logic             full;
    logic             drop_r;
    logic [BCW-1:0]   bit_cnt;
    logic [GCW-1:0]   gap_cnt;
    logic             tick;
    logic             bit_last;
    logic             gap_last;
    logic             release_buf;
    logic             accept_idle;
    logic             accept_buf;
    logic             out_bit;

    assign sum_p0      = sum_ops(data_i);
    assign bit_last    = (bit_cnt == BIT_LAST);
    assign gap_last    = (gap_cnt >= (full ? GAP_REL : GAP_END));
    assign release_buf = (state == GAP) && gap_last && full;
    assign accept_idle = start_i && (state == IDLE);
    // A start coinciding with the buffer release refills the buffer.
    assign accept_buf  = start_i && (state != IDLE) && (!full || release_buf);
    assign out_bit     = (MSB_FIRST != 0) ? shreg[SUM_W-1] : shreg[0];

    bit_tick_gen #(
        .BIT_DIV (BIT_DIV)
    ) u_tick (
        .clk  (clk_i),
        .rst  (rst_i),
        .clr  (state == LOAD),
        .tick (tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ena_o     = 1'b1;
        data_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                ena_o  = 1'b0;
                data_o = out_bit;
                if (tick && bit_last) state_nxt = GAP;
            end
            GAP: begin
                done_o = (gap_cnt == '0);
                if (gap_last) state_nxt = full ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 1: sum captured into the shifter or the pending buffer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg   <= '0;
            pend    <= '0;
            full    <= 1'b0;
            drop_r  <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            drop_r <= start_i && (state != IDLE) && full && !release_buf;

            if (accept_buf) begin
                pend <= sum_p0;
                full <= 1'b1;
            end else if (release_buf) begin
                full <= 1'b0;
            end

            if (accept_idle) begin
                shreg <= sum_p0;
            end else if (release_buf) begin
                shreg <= pend;
            end else if (state == SHIFT && tick) begin
                shreg <= (MSB_FIRST != 0) ? {shreg[SUM_W-2:0], 1'b0}
                                          : {1'b0, shreg[SUM_W-1:1]};
            end

            if (state == LOAD) begin
                bit_cnt <= '0;
            end else if (state == SHIFT && tick) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == GAP && !gap_last) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    assign busy_o = (state != IDLE) || full;
    assign full_o = full;
    assign drop_o = drop_r;

endmodule

// File: tb/tb_multi_sum_serializer.sv
// Bench for multi_sum_serializer: three instances (defaults, MSB-first,
// 5x8-bit operands at 4 cycles per bit) share clock and reset. A monitor
// turns each enable-low window into a frame record (value rebuilt from the
// bit order rule, length, per-bit hold, preceding high interval), which is
// compared with plain-arithmetic sums of the random operands.
module tb_multi_sum_serializer;

    localparam int SW = 11;

    typedef struct {
        int val;
        int len;
        int stable;
        int gap;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [26:0] data_a = '0, data_b = '0;
    logic [39:0] data_c = '0;
    logic        ena_s [3];
    logic        dat_s [3];
    logic        busy_s[3];
    logic        full_s[3];
    logic        drop_s[3];
    logic        done_s[3];

    int n_tests = 0;
    int n_fail  = 0;

    bit     samp    [3][$];
    frame_t frames  [3][$];
    int     gap_run [3] = '{0, 0, 0};
    int     cur_gap [3] = '{0, 0, 0};
    int     done_cnt[3] = '{0, 0, 0};
    int     drop_cnt[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    multi_sum_serializer u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .data_i(data_a),
        .busy_o(busy_s[0]), .full_o(full_s[0]), .drop_o(drop_s[0]),
        .ena_o(ena_s[0]), .data_o(dat_s[0]), .done_o(done_s[0]));

    multi_sum_serializer #(.MSB_FIRST(1)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .data_i(data_b),
        .busy_o(busy_s[1]), .full_o(full_s[1]), .drop_o(drop_s[1]),
        .ena_o(ena_s[1]), .data_o(dat_s[1]), .done_o(done_s[1]));

    multi_sum_serializer #(.N_OPS(5), .OP_W(8), .BIT_DIV(4)) u_c (
        .clk_i(clk), .rst_i(rst), .start_i(start_c), .data_i(data_c),
        .busy_o(busy_s[2]), .full_o(full_s[2]), .drop_o(drop_s[2]),
        .ena_o(ena_s[2]), .data_o(dat_s[2]), .done_o(done_s[2]));

    function automatic int div_of(input int i);
        return (i == 2) ? 4 : 1;
    endfunction

    // Bit i of the frame (transmit order) carries value bit i (LSB first)
    // or SW-1-i (MSB first); each bit must stay put for div samples.
    function automatic frame_t decode(input bit q[$], input int div, input bit msb, input int gap);
        frame_t f;
        f.len = q.size();
        f.gap = gap;
        f.stable = 1;
        f.val = 0;
        if (f.len != SW * div) begin
            f.val = -1;
        end else begin
            for (int i = 0; i < SW; i++) begin
                for (int j = 0; j < div; j++) begin
                    if (q[i*div+j] != q[i*div]) f.stable = 0;
                end
                if (q[i*div]) f.val = f.val | (1 << (msb ? SW - 1 - i : i));
            end
        end
        return f;
    endfunction

    function automatic int ref_sum(input logic [39:0] d, input int n, input int w);
        int s = 0;
        for (int k = 0; k < n; k++) s += int'((d >> (k * w)) & ((40'd1 << w) - 40'd1));
        return s;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!ena_s[i]) begin
                if (samp[i].size() == 0) begin
                    cur_gap[i] = gap_run[i];
                    gap_run[i] = 0;
                end
                samp[i].push_back(dat_s[i]);
            end else begin
                gap_run[i]++;
                if (samp[i].size() > 0) begin
                    frames[i].push_back(decode(samp[i], div_of(i), (i == 1), cur_gap[i]));
                    samp[i].delete();
                end
            end
            if (done_s[i]) done_cnt[i]++;
            if (drop_s[i]) drop_cnt[i]++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while ((busy_s[0] || busy_s[1] || busy_s[2]) && k < max) begin
            tick();
            k++;
        end
        if (k >= max) check_eq("idle_timeout", 1, 0);
        tick(2);
    endtask

    task automatic check_frame(input string tag, input int i, input int idx, input int exp);
        if (frames[i].size() <= idx) begin
            check_eq({tag, "_missing"}, frames[i].size(), idx + 1);
        end else begin
            check_eq({tag, "_len"}, frames[i][idx].len, SW * div_of(i));
            check_eq({tag, "_val"}, frames[i][idx].val, exp);
            check_eq({tag, "_held"}, frames[i][idx].stable, 1);
        end
    endtask

    function automatic logic [26:0] rnd_a();
        logic [26:0] d;
        for (int k = 0; k < 3; k++) d[k*9 +: 9] = 9'($urandom_range(0, 511));
        return d;
    endfunction

    int b0, b1, b2, d0, dr0, e1, e2, e3;
    logic [26:0] v1, v2, v3;

    initial begin
        // Reset and idle state
        rst = 1'b1;
        tick(4);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_ena%0d", i), ena_s[i], 1);
            check_eq($sformatf("rst_data%0d", i), dat_s[i], 0);
            check_eq($sformatf("rst_busy%0d", i), busy_s[i], 0);
            check_eq($sformatf("rst_full%0d", i), full_s[i], 0);
            check_eq($sformatf("rst_drop%0d", i), drop_s[i], 0);
            check_eq($sformatf("rst_done%0d", i), done_s[i], 0);
        end
        rst = 1'b0;
        tick(3);
        check_eq("idle_ena", ena_s[0], 1);
        check_eq("idle_busy", busy_s[0], 0);

        // Sum 6, LSB first, exact frame timing
        b0 = frames[0].size();
        d0 = done_cnt[0];
        data_a = {9'd3, 9'd2, 9'd1};
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_eq("lat1_ena", ena_s[0], 1);
        check_eq("lat1_busy", busy_s[0], 1);
        tick();
        check_eq("lat2_ena", ena_s[0], 0);
        check_eq("bit0", dat_s[0], 0);
        tick();
        check_eq("bit1", dat_s[0], 1);
        tick();
        check_eq("bit2", dat_s[0], 1);
        tick(8);
        check_eq("bit10_ena", ena_s[0], 0);
        check_eq("bit10", dat_s[0], 0);
        tick();
        check_eq("end_ena", ena_s[0], 1);
        check_eq("end_data", dat_s[0], 0);
        check_eq("end_done", done_s[0], 1);
        tick();
        check_eq("gap2_done", done_s[0], 0);
        wait_idle(100);
        check_frame("sum6", 0, b0, 6);
        check_eq("sum6_dones", done_cnt[0] - d0, 1);

        // Max operands, LSB and MSB first; 5 operands at 4 cycles per bit
        b0 = frames[0].size();
        b1 = frames[1].size();
        b2 = frames[2].size();
        data_a = '1;
        data_b = '1;
        data_c = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        start_a = 1'b1;
        start_b = 1'b1;
        start_c = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        wait_idle(200);
        check_frame("max_lsb", 0, b0, 1533);
        check_frame("max_msb", 1, b1, 1533);
        check_frame("div4_sum15", 2, b2, 15);

        // Random operands on all three instances
        for (int r = 0; r < 8; r++) begin
            b0 = frames[0].size();
            b1 = frames[1].size();
            b2 = frames[2].size();
            data_a = rnd_a();
            data_b = rnd_a();
            for (int k = 0; k < 5; k++) data_c[k*8 +: 8] = 8'($urandom_range(0, 255));
            start_a = 1'b1;
            start_b = 1'b1;
            start_c = 1'b1;
            tick();
            start_a = 1'b0;
            start_b = 1'b0;
            start_c = 1'b0;
            wait_idle(200);
            check_frame($sformatf("rnd%0d_a", r), 0, b0, ref_sum(40'(data_a), 3, 9));
            check_frame($sformatf("rnd%0d_b", r), 1, b1, ref_sum(40'(data_b), 3, 9));
            check_frame($sformatf("rnd%0d_c", r), 2, b2, ref_sum(data_c, 5, 8));
        end

        // Three starts 5 cycles apart: send, buffer, drop
        b0 = frames[0].size();
        d0 = done_cnt[0];
        dr0 = drop_cnt[0];
        v1 = rnd_a();
        v2 = rnd_a();
        v3 = rnd_a();
        data_a = v1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick(4);
        data_a = v2;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_eq("pend_full", full_s[0], 1);
        check_eq("pend_nodrop", drop_s[0], 0);
        tick(4);
        data_a = v3;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_eq("drop_pulse", drop_s[0], 1);
        check_eq("drop_full", full_s[0], 1);
        tick();
        check_eq("drop_once", drop_s[0], 0);
        wait_idle(300);
        check_eq("pend_frames", frames[0].size() - b0, 2);
        check_frame("pend_f1", 0, b0, ref_sum(40'(v1), 3, 9));
        check_frame("pend_f2", 0, b0 + 1, ref_sum(40'(v2), 3, 9));
        if (frames[0].size() > b0 + 1) check_eq("pend_gap", frames[0][b0+1].gap, 2);
        check_eq("pend_dones", done_cnt[0] - d0, 2);
        check_eq("pend_drops", drop_cnt[0] - dr0, 1);

        // Start in the exact cycle the buffer is released: accepted
        b0 = frames[0].size();
        dr0 = drop_cnt[0];
        v1 = rnd_a();
        v2 = rnd_a();
        v3 = rnd_a();
        data_a = v1;
        start_a = 1'b1;
        tick();
        data_a = v2;
        tick();
        start_a = 1'b0;
        check_eq("rel_full", full_s[0], 1);
        tick(11);
        check_eq("rel_gap_done", done_s[0], 1);
        data_a = v3;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_eq("rel_refill_full", full_s[0], 1);
        check_eq("rel_nodrop", drop_s[0], 0);
        wait_idle(400);
        check_eq("rel_frames", frames[0].size() - b0, 3);
        check_frame("rel_f1", 0, b0, ref_sum(40'(v1), 3, 9));
        check_frame("rel_f2", 0, b0 + 1, ref_sum(40'(v2), 3, 9));
        check_frame("rel_f3", 0, b0 + 2, ref_sum(40'(v3), 3, 9));
        check_eq("rel_drops", drop_cnt[0] - dr0, 0);

        // Reset at bit 5 with the buffer full
        d0 = done_cnt[0];
        v1 = rnd_a();
        v2 = rnd_a();
        e1 = ref_sum(40'(v1), 3, 9);
        data_a = v1;
        start_a = 1'b1;
        tick();
        data_a = v2;
        tick();
        start_a = 1'b0;
        tick(5);
        check_eq("rstm_bit5", dat_s[0], (e1 >> 5) & 1);
        check_eq("rstm_full_before", full_s[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstm_ena", ena_s[0], 1);
        check_eq("rstm_data", dat_s[0], 0);
        check_eq("rstm_full", full_s[0], 0);
        check_eq("rstm_busy", busy_s[0], 0);
        check_eq("rstm_done", done_s[0], 0);
        tick(20);
        check_eq("rstm_no_done", done_cnt[0] - d0, 0);
        check_eq("rstm_stay_idle", busy_s[0], 0);
        b0 = frames[0].size();
        v3 = rnd_a();
        data_a = v3;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_idle(200);
        check_frame("rstm_fresh", 0, b0, ref_sum(40'(v3), 3, 9));
        check_eq("rstm_fresh_done", done_cnt[0] - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
